// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions for the 250 MHz packet format and the arbiter state type.
package axis_pkg;

    localparam int unsigned AXIS_DATA_W = 512;
    localparam int unsigned AXIS_KEEP_W = 64;
    localparam int unsigned AXIS_USER_W = 16;

    typedef struct packed {
        logic [AXIS_DATA_W-1:0] tdata;
        logic [AXIS_KEEP_W-1:0] tkeep;
        logic                   tlast;
        logic [AXIS_USER_W-1:0] tuser_size;
        logic [AXIS_USER_W-1:0] tuser_src;
        logic [AXIS_USER_W-1:0] tuser_dst;
    } axis_beat_t;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

endpackage

// File: rtl/axis_pkt_arbiter_if.sv
// Packed AXI-Stream bundle carrying N lanes; lane i occupies slice i of every field.
interface axis_pkt_arbiter_if #(
    parameter int unsigned N      = 2,
    parameter int unsigned DATA_W = axis_pkg::AXIS_DATA_W
) ();

    logic [N-1:0]                          tvalid;
    logic [DATA_W*N-1:0]                   tdata;
    logic [DATA_W/8*N-1:0]                 tkeep;
    logic [N-1:0]                          tlast;
    logic [axis_pkg::AXIS_USER_W*N-1:0]    tuser_size;
    logic [axis_pkg::AXIS_USER_W*N-1:0]    tuser_src;
    logic [axis_pkg::AXIS_USER_W*N-1:0]    tuser_dst;
    logic [N-1:0]                          tready;

    modport master (
        output tvalid, tdata, tkeep, tlast, tuser_size, tuser_src, tuser_dst,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast, tuser_size, tuser_src, tuser_dst,
        output tready
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin select: first requesting index after last_i, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N = 2,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    logic [W-1:0] cand;

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        idx_o   = last_i;
        found_o = 1'b0;
        cand    = '0;
        for (int unsigned off = N; off > 0; off--) begin
            cand = W'((32'(last_i) + off) % N);
            if (req_i[cand]) begin
                idx_o   = cand;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-atomic round-robin merge of NUM_INTF AXI-Stream slaves onto one registered master.
module axis_pkt_arbiter
    import axis_pkg::*;
#(
    parameter int unsigned NUM_INTF = 2,
    parameter int unsigned DATA_W   = AXIS_DATA_W
) (
    input  logic                        axis_aclk,
    input  logic                        axis_rst,
    axis_pkt_arbiter_if.slave           s_axis,
    axis_pkt_arbiter_if.master          m_axis,
    output logic [$clog2(NUM_INTF)-1:0] grant_id,
    output logic [31:0]                 pkt_cnt
);

    localparam int unsigned GW = $clog2(NUM_INTF);
    localparam int unsigned KW = DATA_W / 8;
    localparam int unsigned UW = AXIS_USER_W;

    arb_state_t  state_q;
    logic [GW-1:0] grant_q;
    axis_beat_t  out_q, out_d;
    logic        m_valid_q, m_valid_d;
    logic [31:0] pkt_cnt_q, pkt_cnt_d;

    logic [GW-1:0] pick_idx;
    logic          pick_found;
    logic          ready_g;
    logic          accept;
    axis_beat_t    in_beat;

    rr_pick #(
        .N (NUM_INTF),
        .W (GW)
    ) u_pick (
        .req_i   (s_axis.tvalid),
        .last_i  (grant_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_comb begin
        in_beat            = '0;
        in_beat.tdata      = s_axis.tdata[DATA_W*grant_q +: DATA_W];
        in_beat.tkeep      = s_axis.tkeep[KW*grant_q +: KW];
        in_beat.tlast      = s_axis.tlast[grant_q];
        in_beat.tuser_size = s_axis.tuser_size[UW*grant_q +: UW];
        in_beat.tuser_src  = s_axis.tuser_src[UW*grant_q +: UW];
        in_beat.tuser_dst  = s_axis.tuser_dst[UW*grant_q +: UW];
    end

    // Only the locked interface may move, and only when the output slot frees this cycle.
    assign ready_g = (state_q == LOCKED) && (!m_valid_q || m_axis.tready[0]);
    assign accept  = ready_g && s_axis.tvalid[grant_q];

    always_comb begin
        s_axis.tready          = '0;
        s_axis.tready[grant_q] = ready_g;
    end

    always_comb begin
        out_d     = accept ? in_beat : out_q;
        m_valid_d = accept ? 1'b1 : (m_axis.tready[0] ? 1'b0 : m_valid_q);
        pkt_cnt_d = pkt_cnt_q + 32'(m_valid_q && m_axis.tready[0] && out_q.tlast);
    end

    always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst) begin
            state_q   <= IDLE;
            grant_q   <= GW'(NUM_INTF - 1);
            out_q     <= '0;
            m_valid_q <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            out_q     <= out_d;
            m_valid_q <= m_valid_d;
            pkt_cnt_q <= pkt_cnt_d;
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant_q <= pick_idx;
                        state_q <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (accept && in_beat.tlast) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_axis.tvalid     = m_valid_q;
    assign m_axis.tdata      = out_q.tdata;
    assign m_axis.tkeep      = out_q.tkeep;
    assign m_axis.tlast      = out_q.tlast;
    assign m_axis.tuser_size = out_q.tuser_size;
    assign m_axis.tuser_src  = out_q.tuser_src;
    assign m_axis.tuser_dst  = out_q.tuser_dst;
    assign grant_id          = grant_q;
    assign pkt_cnt           = pkt_cnt_q;

endmodule

// File: doc/axis_pkt_arbiter.md
Name: axis_pkt_arbiter

Overview:
- Packet-atomic round-robin arbiter. Merges NUM_INTF packed AXI-Stream slave interfaces into one AXI-Stream master.
- Uses the 250 MHz packet format: 512b tdata, 64b tkeep, tlast, and 16b tuser_size/src/dst.
- Typical placement: ahead of a single QDMA C2H or adapter TX port, so that several switch outputs share one sink.
- Performs the opposite of the per-port fan-out done around the stream switch: it fans N streams in.

Parameters:
- NUM_INTF, 2: number of packed slave interfaces; legal range 2..8.
- DATA_W, 512: tdata width; tkeep width is DATA_W/8.

Ports:
- axis_aclk  in  1  sole clock.
- axis_rst  in  1  asynchronous, active-high reset.
- s_axis_tvalid  in  NUM_INTF  per-interface valid; interface i is bit i.
- s_axis_tdata  in  DATA_W*NUM_INTF  interface i occupies [DATA_W*i +: DATA_W].
- s_axis_tkeep  in  DATA_W/8*NUM_INTF  packed like tdata.
- s_axis_tlast  in  NUM_INTF  end of packet.
- s_axis_tuser_size  in  16*NUM_INTF  packet byte length.
- s_axis_tuser_src  in  16*NUM_INTF  source id.
- s_axis_tuser_dst  in  16*NUM_INTF  destination id.
- s_axis_tready  out  NUM_INTF  per-interface ready.
- m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser_size, m_axis_tuser_src, m_axis_tuser_dst  out  1/DATA_W/DATA_W/8/1/16/16/16  merged stream.
- m_axis_tready  in  1  sink ready.
- grant_id  out  $clog2(NUM_INTF)  currently or last granted interface.
- pkt_cnt  out  32  packets forwarded; wraps at 2^32.

Behaviour:
- Reset: all state and outputs clear while axis_rst is high.
  - m_axis_tvalid=0, all m_axis payload=0, s_axis_tready=0.
  - grant_id=NUM_INTF-1, so the first arbitration starts at interface 0.
  - pkt_cnt=0, FSM=IDLE.
- FSM states: IDLE and LOCKED.
- IDLE:
  - If any s_axis_tvalid is set, register the grant to the first valid index scanning grant_id+1, grant_id+2, ... modulo NUM_INTF.
  - Move to LOCKED on the next edge. No beat is accepted in IDLE.
  - If no valid is set, stay in IDLE and hold grant_id.
- LOCKED:
  - s_axis_tready[g] = (!m_axis_tvalid || m_axis_tready), where g is grant_id.
  - All other s_axis_tready bits are 0.
  - On an accepted beat (valid & ready on g), copy tdata/tkeep/tlast/tuser of interface g into the output register. m_axis_tvalid is 1 the next cycle.
  - Latency: exactly 1 cycle from input handshake to output valid.
  - Throughput: 1 beat/cycle within a packet.
  - An accepted beat with tlast=1 returns the FSM to IDLE. This gives a 1-cycle arbitration bubble between packets.
- Output register:
  - When m_axis_tvalid=1 and m_axis_tready=0, output payload is held stable (AXIS rule).
  - When m_axis_tready=1 and no new beat is accepted, m_axis_tvalid drops to 0 after the handshake.
- pkt_cnt: increments by 1 on each output handshake with m_axis_tlast=1. 0xFFFFFFFF wraps to 0.
- Packet atomicity: beats of different interfaces never interleave. A granted interface that deasserts tvalid mid-packet keeps the lock; there is no timeout.
- Simultaneous events:
  - The tlast accept on interface g and new valids on other interfaces are handled normally: the next grant is chosen in the following IDLE cycle.
  - If only g is valid, g is re-granted.
- Single-beat packets (tlast on the first beat) are legal.
- Reset mid-packet: the packet is truncated and output is dropped immediately. No recovery of the partial packet is attempted. Upstream is responsible for flushing.
- tuser fields are passed through per beat unmodified. No check is made for consistency of tuser_size against tkeep.

Decomposition:
- Shared package axis_pkg holds:
  - localparams AXIS_DATA_W=512, AXIS_KEEP_W=64, AXIS_USER_W=16.
  - typedef axis_beat_t: packed struct of tdata, tkeep, tlast, tuser_size, tuser_src, tuser_dst.
  - typedef enum arb_state_t {IDLE, LOCKED}.
- One sub-module, rr_pick: combinational round-robin priority select. Inputs are the request vector and the last grant; outputs are the next index and a found flag.
- The FSM, payload mux, output register and counter live in the top level.

Test Plan:
- Reset then idle: all tvalid=0 for 20 cycles -> m_axis_tvalid stays 0, s_axis_tready=0, pkt_cnt=0, grant_id=NUM_INTF-1.
- Single source: interface 0 sends a 3-beat packet (size=192, src=0x0001, dst=0x0002), m_axis_tready=1 -> 3 output beats in order, each 1 cycle after its input handshake, tlast on beat 3; pkt_cnt=1.
- Contention:
  - Stimulus: interfaces 0 and 1 each send 4 back-to-back 2-beat packets, tready=1.
  - Required: grants alternate 0,1,0,1,... (8 packets total).
  - Required: there is no beat interleaving within any packet and exactly 1 bubble cycle between packets; pkt_cnt=8.
- Backpressure: m_axis_tready toggles 1,0,0,1 during a 5-beat packet -> output payload is stable while stalled, the granted s_axis_tready is 0 whenever the output register is full and stalled, and all 5 beats arrive with no loss or duplicates.
- Mid-packet gap: granted interface 1 drops tvalid for 3 cycles mid-packet while interface 0 is valid -> the lock is held, interface 0 gets no tready until interface 1's tlast is accepted, then interface 0 is granted.
- Reset mid-packet plus wrap:
  - Reset mid-packet: assert axis_rst on beat 2 of 4 -> outputs clear asynchronously and the FSM is IDLE after release.
  - Counter wrap: force pkt_cnt=0xFFFFFFFF before one packet completes -> pkt_cnt=0.
